ddr4_v2_2_20_cal_wr_pat: RTL and testbench

Calibration write-pattern generator for one byte lane. It accepts a write request from the calibration sequencer, waits a programmable latency, and emits a train of 8-beat data and mask words. Its outputs `DQOut`, `DMOut`, `wrDataVal` and `wrOffset` feed the per-byte write stage `ddr4_v2_2_20_cal_wr_byte` directly.

---
 rtl/ddr4_v2_2_20_cal_wr_pat_pkg.sv | 8 +
 rtl/ddr4_v2_2_20_cal_wr_pat_if.sv | 18 +
 rtl/ddr4_v2_2_20_cal_wr_lfsr.sv | 24 ++
 rtl/ddr4_v2_2_20_cal_wr_pat.sv | 79 +++++++
 tb/tb_ddr4_v2_2_20_cal_wr_pat.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/ddr4_v2_2_20_cal_wr_pat_pkg.sv
// ddr4_v2_2_20_cal_wr_pat_pkg: shared types and constants for the calibration write-pattern generator
package ddr4_v2_2_20_cal_wr_pat_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_BURST, ST_DONE} state_t;
    typedef enum logic [2:0] {PAT_ZERO, PAT_ONES, PAT_CLK, PAT_WALK1, PAT_PRBS7, PAT_MASK} pat_t;
    localparam logic [6:0] PRBS_SEED = 7'h7F;
    localparam logic [7:0] CLK_BYTE  = 8'h55;
    localparam logic [7:0] MASK_DM   = 8'hAA;
endpackage

// File: rtl/ddr4_v2_2_20_cal_wr_pat_if.sv
// ddr4_v2_2_20_cal_wr_pat_if: request handshake and write-data bus of the pattern generator
interface ddr4_v2_2_20_cal_wr_pat_if;
    logic        wr_req;
    logic [2:0]  wr_pattern;
    logic [7:0]  wr_bursts;
    logic [1:0]  wr_offset;
    logic        wr_abort;
    logic        wr_ready;
    logic        wr_done;
    logic [63:0] DQOut;
    logic [7:0]  DMOut;
    logic        wrDataVal;
    logic [2:1]  wrOffset;
    modport master (output wr_req, wr_pattern, wr_bursts, wr_offset, wr_abort,
                    input wr_ready, wr_done, DQOut, DMOut, wrDataVal, wrOffset);
    modport slave  (input wr_req, wr_pattern, wr_bursts, wr_offset, wr_abort,
                    output wr_ready, wr_done, DQOut, DMOut, wrDataVal, wrOffset);
endinterface

// File: rtl/ddr4_v2_2_20_cal_wr_lfsr.sv
// ddr4_v2_2_20_cal_wr_lfsr: x^7+x^6+1 PRBS7 source producing 8 beats per advance
module ddr4_v2_2_20_cal_wr_lfsr
    import ddr4_v2_2_20_cal_wr_pat_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       seed,
    input  logic       advance,
    output logic [7:0] beats
);
    logic [6:0] s_q, s_d, t;
    always_comb begin
        t = s_q;
        beats = '0;
        for (int b = 0; b < 8; b++) begin
            beats[b] = t[6];
            t = {t[5:0], t[6] ^ t[5]};
        end
        s_d = seed ? PRBS_SEED : advance ? t : s_q;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) s_q <= PRBS_SEED;
        else     s_q <= s_d;
endmodule

// File: rtl/ddr4_v2_2_20_cal_wr_pat.sv
// ddr4_v2_2_20_cal_wr_pat: per-byte calibration write-pattern generator with programmable latency
module ddr4_v2_2_20_cal_wr_pat
    import ddr4_v2_2_20_cal_wr_pat_pkg::*;
#(
    parameter real TCQ    = 0.1,
    parameter int  WR_LAT = 2
) (
    input logic clk,
    input logic rst,
    ddr4_v2_2_20_cal_wr_pat_if.slave bus
);
    state_t      state_q, state_d;
    logic [3:0]  lat_q;
    logic [8:0]  n_q;
    logic [7:0]  bursts_q;
    logic [2:0]  pat_q;
    logic [1:0]  off_q;
    logic        ready_q, done_q, val_q;
    logic [63:0] dq_q, dq_d;
    logic [7:0]  dm_q, dm_d, beats;
    logic        accept, emit, last;
    assign accept = state_q == ST_IDLE && ready_q && bus.wr_req && !bus.wr_abort;
    assign emit   = state_q == ST_BURST && !bus.wr_abort;
    // 9-bit compare so a 256-word burst terminates instead of wrapping
    assign last   = n_q == {1'b0, bursts_q};
    ddr4_v2_2_20_cal_wr_lfsr u_lfsr (
        .clk(clk), .rst(rst), .seed(accept), .advance(emit), .beats(beats)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    always_comb begin
        state_d = bus.wr_abort ? ST_IDLE :
                  state_q == ST_IDLE  ? (accept ? (WR_LAT == 0 ? ST_BURST : ST_ARM) : ST_IDLE) :
                  state_q == ST_ARM   ? (lat_q == 4'(WR_LAT - 1) ? ST_BURST : ST_ARM) :
                  state_q == ST_BURST ? (last ? ST_DONE : ST_BURST) : ST_IDLE;
    end
    always_comb begin
        dq_d = '0;
        for (int i = 0; i < 8; i++)
            dq_d[i*8 +: 8] = !emit ? 8'h00 :
                             pat_q == PAT_ONES || pat_q == PAT_MASK ? 8'hFF :
                             pat_q == PAT_CLK   ? CLK_BYTE :
                             pat_q == PAT_WALK1 ? {8{n_q[2:0] == 3'(i)}} :
                             pat_q == PAT_PRBS7 ? (i[0] ? ~beats : beats) : 8'h00;
        dm_d = emit && pat_q == PAT_MASK ? MASK_DM : 8'h00;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            lat_q    <= '0;
            n_q      <= '0;
            bursts_q <= '0;
            pat_q    <= '0;
            off_q    <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            val_q    <= 1'b0;
            dq_q     <= '0;
            dm_q     <= '0;
        end else begin
            lat_q    <= accept ? 4'd0 : lat_q + 4'd1;
            n_q      <= accept ? 9'd0 : state_q == ST_BURST ? n_q + 9'd1 : n_q;
            bursts_q <= accept ? bus.wr_bursts : bursts_q;
            pat_q    <= accept ? bus.wr_pattern : pat_q;
            off_q    <= accept ? bus.wr_offset : off_q;
            // hold ready low through the cycle that shows wr_done
            ready_q  <= state_d == ST_IDLE && state_q != ST_DONE;
            done_q   <= state_q == ST_DONE && !bus.wr_abort;
            val_q    <= emit;
            dq_q     <= dq_d;
            dm_q     <= dm_d;
        end
    assign bus.wr_ready  = ready_q;
    assign bus.wr_done   = done_q;
    assign bus.wrDataVal = val_q;
    assign bus.DQOut     = dq_q;
    assign bus.DMOut     = dm_q;
    assign bus.wrOffset  = off_q;
endmodule

// File: tb/tb_ddr4_v2_2_20_cal_wr_pat.sv
// tb_ddr4_v2_2_20_cal_wr_pat: directed self-checking bench for the write-pattern generator
module tb_ddr4_v2_2_20_cal_wr_pat;
    localparam int WR_LAT = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [63:0] got_dq [256];
    logic [7:0]  got_dm [256];
    ddr4_v2_2_20_cal_wr_pat_if bus();
    ddr4_v2_2_20_cal_wr_pat #(.WR_LAT(WR_LAT)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [2:0] pat, input int nb, input logic [1:0] off);
        int k;
        bus.wr_pattern = pat;
        bus.wr_bursts  = 8'(nb);
        bus.wr_offset  = off;
        bus.wr_req     = 1'b1;
        chk("ready_pre", bus.wr_ready, 1);
        tick();
        bus.wr_req = 1'b0;
        chk("ready_fall", bus.wr_ready, 0);
        k = 0;
        while (!bus.wrDataVal && k < 40) begin
            tick();
            k++;
        end
        chk("latency", k, WR_LAT + 1);
        for (int n = 0; n <= nb; n++) begin
            chk("valid", bus.wrDataVal, 1);
            chk("done_early", bus.wr_done, 0);
            got_dq[n] = bus.DQOut;
            got_dm[n] = bus.DMOut;
            tick();
        end
        chk("val_end", bus.wrDataVal, 0);
        chk("done", bus.wr_done, 1);
        chk("dq_idle", bus.DQOut, 0);
        chk("ready_in_done", bus.wr_ready, 0);
        chk("offset", bus.wrOffset, off);
        tick();
        chk("done_pulse", bus.wr_done, 0);
        chk("ready_back", bus.wr_ready, 1);
    endtask

    initial begin
        int seen;
        bus.wr_req = 0; bus.wr_pattern = 0; bus.wr_bursts = 0; bus.wr_offset = 0; bus.wr_abort = 0;
        repeat (2) tick();
        chk("rst_ready", bus.wr_ready, 1);
        chk("rst_done", bus.wr_done, 0);
        chk("rst_val", bus.wrDataVal, 0);
        chk("rst_dq", bus.DQOut, 0);
        chk("rst_dm", bus.DMOut, 0);
        chk("rst_off", bus.wrOffset, 0);
        rst = 1'b0;
        tick();
        run(3'd1, 0, 2'b00);
        chk("ones_dq", got_dq[0], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("ones_dm", got_dm[0], 0);
        run(3'd2, 3, 2'b10);
        for (int n = 0; n < 4; n++) chk("clk_dq", got_dq[n], {8{8'h55}});
        repeat (3) tick();
        chk("offset_held", bus.wrOffset, 2'b10);
        run(3'd3, 9, 2'b01);
        for (int n = 0; n < 10; n++) chk("walk1_dq", got_dq[n], 64'hFF << ((n % 8) * 8));
        run(3'd4, 1, 2'b00);
        chk("prbs_w0", got_dq[0], 64'h807F_807F_807F_807F);
        chk("prbs_w1", got_dq[1], 64'hDF20_DF20_DF20_DF20);
        run(3'd4, 0, 2'b00);
        chk("prbs_reseed", got_dq[0], 64'h807F_807F_807F_807F);
        run(3'd6, 1, 2'b00);
        chk("pat6_dq", got_dq[0] | got_dq[1], 0);
        run(3'd5, 255, 2'b11);
        for (int n = 0; n < 256; n++) begin
            chk("mask_dm", got_dm[n], 8'hAA);
            chk("mask_dq", got_dq[n], 64'hFFFF_FFFF_FFFF_FFFF);
        end
        // abort while word 2 of a 10-word burst is on the bus
        bus.wr_pattern = 3'd1; bus.wr_bursts = 8'd9; bus.wr_req = 1'b1;
        tick();
        bus.wr_req = 1'b0;
        seen = 0;
        while (!bus.wrDataVal && seen < 40) begin tick(); seen++; end
        chk("abort_lat", seen, WR_LAT + 1);
        repeat (2) tick();
        chk("abort_w2_val", bus.wrDataVal, 1);
        bus.wr_abort = 1'b1;
        tick();
        bus.wr_abort = 1'b0;
        chk("abort_val", bus.wrDataVal, 0);
        chk("abort_dq", bus.DQOut, 0);
        seen = 0;
        for (int i = 0; i < 14; i++) begin
            seen |= {31'd0, bus.wr_done | bus.wrDataVal};
            tick();
        end
        chk("abort_no_done", seen, 0);
        chk("abort_ready", bus.wr_ready, 1);
        bus.wr_req = 1'b1; bus.wr_abort = 1'b1;
        tick();
        bus.wr_req = 1'b0; bus.wr_abort = 1'b0;
        chk("req_abort_ready", bus.wr_ready, 1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            seen |= {31'd0, bus.wrDataVal};
            tick();
        end
        chk("req_abort_noval", seen, 0);
        // asynchronous reset while in ARM, no clock edge in between
        bus.wr_pattern = 3'd1; bus.wr_bursts = 8'd5; bus.wr_offset = 2'b11; bus.wr_req = 1'b1;
        tick();
        bus.wr_req = 1'b0;
        chk("arm_ready", bus.wr_ready, 0);
        chk("arm_off", bus.wrOffset, 2'b11);
        #2 rst = 1'b1;
        #1;
        chk("async_ready", bus.wr_ready, 1);
        chk("async_off", bus.wrOffset, 0);
        chk("async_val", bus.wrDataVal, 0);
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            seen |= {31'd0, bus.wrDataVal | bus.wr_done};
            tick();
        end
        chk("post_rst_idle", seen, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
